pipe_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage RV32I pipeline (F, D, E, M, W).
- Drives the STALL/FLUSH pair of every stage latch and the redirect PC toward fetch.
- Resolves memory wait, load-use hazard, taken branch, halt request and memory timeout.
- Stage latch semantics: STALL holds the latch; STALL has priority over FLUSH; FLUSH alone loads a bubble (valid=0).

---
 rtl/pipe_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Central stall/flush/redirect controller for the 5-stage RV32I pipeline.
// Stage controls are combinational; the FSM, wait counter, error flag and stall counter are registered.
module pipe_ctrl #(
  parameter int unsigned TIMEOUT  = 256,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  D_REG_S1,
  input  logic [4:0]  D_REG_S2,
  input  logic        D_USES_S1,
  input  logic        D_USES_S2,
  input  logic        E_VALID,
  input  logic        E_IS_LOAD,
  input  logic [4:0]  E_REG_D,
  input  logic        E_BR_TAKEN,
  input  logic [31:0] E_BR_ADDR,
  input  logic        M_MEM_REQ,
  input  logic        M_MEM_READY,
  input  logic        HALT_REQ,
  output logic        F_STALL,
  output logic        D_STALL,
  output logic        E_STALL,
  output logic        M_STALL,
  output logic        W_STALL,
  output logic        F_FLUSH,
  output logic        D_FLUSH,
  output logic        E_FLUSH,
  output logic        M_FLUSH,
  output logic        W_FLUSH,
  output logic [31:0] NEW_PC,
  output logic        NEW_PC_VALID,
  output logic        HALTED,
  output logic        MEM_ERR,
  output logic [31:0] STALL_CNT
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALT    = 2'd2,
    ERR     = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             mem_err_q, mem_err_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;

  logic        memwait, loaduse, br_taken;
  logic [4:0]  stall_c, flush_c;
  logic [31:0] new_pc_c;
  logic        new_pc_valid_c, halted_c;

  assign memwait  = M_MEM_REQ & ~M_MEM_READY;
  assign br_taken = E_BR_TAKEN & E_VALID;
  assign loaduse  = E_VALID & E_IS_LOAD & (E_REG_D != 5'd0) &
                    ((D_USES_S1 & (D_REG_S1 == E_REG_D)) |
                     (D_USES_S2 & (D_REG_S2 == E_REG_D)));

  // Next state and stage controls; vectors are ordered {F, D, E, M, W}
  always_comb begin
    state_d        = state_q;
    wcnt_d         = wcnt_q;
    stall_c        = 5'b00000;
    flush_c        = 5'b00000;
    new_pc_c       = 32'd0;
    new_pc_valid_c = 1'b0;
    halted_c       = 1'b0;

    case (state_q)
      RUN, MEMWAIT: begin
        if (memwait) begin
          stall_c = 5'b11110;
          flush_c = 5'b00001;
        end else if (br_taken) begin
          flush_c        = 5'b01100;
          new_pc_c       = E_BR_ADDR;
          new_pc_valid_c = 1'b1;
        end else if (loaduse) begin
          stall_c = 5'b11000;
          flush_c = 5'b00100;
        end

        if (state_q == RUN) begin
          if (memwait) begin
            state_d = MEMWAIT;
            wcnt_d  = CNT_W'(1);
          end else if (HALT_REQ && !br_taken) begin
            state_d = HALT;
          end
        end else begin
          if (!memwait) begin
            state_d = RUN;
            wcnt_d  = '0;
          end else if (wcnt_q == LAST_WAIT) begin
            state_d = ERR;
          end else begin
            wcnt_d = wcnt_q + CNT_W'(1);
          end
        end
      end
      HALT: begin
        stall_c  = 5'b11111;
        halted_c = HALT_REQ;
        if (!HALT_REQ) state_d = RUN;
      end
      ERR: begin
        flush_c        = 5'b11111;
        new_pc_c       = TRAP_VEC;
        new_pc_valid_c = 1'b1;
        wcnt_d         = '0;
        state_d        = RUN;
      end
      default: state_d = RUN;
    endcase

    // Everything toward the pipeline is quiet while reset is held
    if (RST) begin
      stall_c        = 5'b00000;
      flush_c        = 5'b00000;
      new_pc_c       = 32'd0;
      new_pc_valid_c = 1'b0;
      halted_c       = 1'b0;
    end

    mem_err_d   = mem_err_q | (state_q == ERR);
    stall_cnt_d = stall_c[4] ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      wcnt_q      <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign {F_STALL, D_STALL, E_STALL, M_STALL, W_STALL} = stall_c;
  assign {F_FLUSH, D_FLUSH, E_FLUSH, M_FLUSH, W_FLUSH} = flush_c;
  assign NEW_PC       = new_pc_c;
  assign NEW_PC_VALID = new_pc_valid_c;
  assign HALTED       = halted_c;
  assign MEM_ERR      = mem_err_q;
  assign STALL_CNT    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazards, branches, memory wait/timeout, halt and reset.
module tb_pipe_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  D_REG_S1, D_REG_S2, E_REG_D;
  logic        D_USES_S1, D_USES_S2, E_VALID, E_IS_LOAD, E_BR_TAKEN;
  logic [31:0] E_BR_ADDR;
  logic        M_MEM_REQ, M_MEM_READY, HALT_REQ;
  logic        F_STALL, D_STALL, E_STALL, M_STALL, W_STALL;
  logic        F_FLUSH, D_FLUSH, E_FLUSH, M_FLUSH, W_FLUSH;
  logic [31:0] NEW_PC, STALL_CNT;
  logic        NEW_PC_VALID, HALTED, MEM_ERR;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.TIMEOUT(4), .TRAP_VEC(32'h0000_0100)) dut (
    .CLK(CLK), .RST(RST),
    .D_REG_S1(D_REG_S1), .D_REG_S2(D_REG_S2),
    .D_USES_S1(D_USES_S1), .D_USES_S2(D_USES_S2),
    .E_VALID(E_VALID), .E_IS_LOAD(E_IS_LOAD), .E_REG_D(E_REG_D),
    .E_BR_TAKEN(E_BR_TAKEN), .E_BR_ADDR(E_BR_ADDR),
    .M_MEM_REQ(M_MEM_REQ), .M_MEM_READY(M_MEM_READY), .HALT_REQ(HALT_REQ),
    .F_STALL(F_STALL), .D_STALL(D_STALL), .E_STALL(E_STALL),
    .M_STALL(M_STALL), .W_STALL(W_STALL),
    .F_FLUSH(F_FLUSH), .D_FLUSH(D_FLUSH), .E_FLUSH(E_FLUSH),
    .M_FLUSH(M_FLUSH), .W_FLUSH(W_FLUSH),
    .NEW_PC(NEW_PC), .NEW_PC_VALID(NEW_PC_VALID), .HALTED(HALTED),
    .MEM_ERR(MEM_ERR), .STALL_CNT(STALL_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stalls();
    return {27'd0, F_STALL, D_STALL, E_STALL, M_STALL, W_STALL};
  endfunction

  function automatic logic [31:0] flushes();
    return {27'd0, F_FLUSH, D_FLUSH, E_FLUSH, M_FLUSH, W_FLUSH};
  endfunction

  task automatic idle();
    D_REG_S1 = 5'd0; D_REG_S2 = 5'd0; D_USES_S1 = 1'b0; D_USES_S2 = 1'b0;
    E_VALID = 1'b0; E_IS_LOAD = 1'b0; E_REG_D = 5'd0;
    E_BR_TAKEN = 1'b0; E_BR_ADDR = 32'd0;
    M_MEM_REQ = 1'b0; M_MEM_READY = 1'b0; HALT_REQ = 1'b0;
  endtask

  // Advance to the next drive point, mid-cycle between posedges
  task automatic step();
    @(negedge CLK);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic ctrl(input string tag, input logic [4:0] st, input logic [4:0] fl,
                      input logic npv, input logic [31:0] npc);
    chk({tag, "_stall"}, stalls(), {27'd0, st});
    chk({tag, "_flush"}, flushes(), {27'd0, fl});
    chk({tag, "_npv"}, {31'd0, NEW_PC_VALID}, {31'd0, npv});
    chk({tag, "_npc"}, NEW_PC, npc);
  endtask

  initial begin
    idle();
    RST = 1'b1;
    M_MEM_REQ = 1'b1; E_VALID = 1'b1; E_BR_TAKEN = 1'b1; HALT_REQ = 1'b1;
    step(); settle();
    ctrl("rst_quiet", 5'b00000, 5'b00000, 1'b0, 32'd0);
    chk("rst_halted", {31'd0, HALTED}, 32'd0);
    step(); idle(); RST = 1'b0; settle();
    chk("rst_cnt", STALL_CNT, 32'd0);
    chk("rst_err", {31'd0, MEM_ERR}, 32'd0);
    ctrl("rst_idle", 5'b00000, 5'b00000, 1'b0, 32'd0);

    // Load-use on rs2
    step(); E_VALID = 1'b1; E_IS_LOAD = 1'b1; E_REG_D = 5'd5; D_USES_S2 = 1'b1; D_REG_S2 = 5'd5; settle();
    ctrl("lu", 5'b11000, 5'b00100, 1'b0, 32'd0);
    step(); idle(); settle();
    chk("lu_cnt", STALL_CNT, 32'd1);
    // x0 destination never creates a hazard
    step(); E_VALID = 1'b1; E_IS_LOAD = 1'b1; E_REG_D = 5'd0; D_USES_S1 = 1'b1; D_REG_S1 = 5'd0; settle();
    ctrl("lu_x0", 5'b00000, 5'b00000, 1'b0, 32'd0);
    step(); idle(); settle();
    chk("lu_x0_cnt", STALL_CNT, 32'd1);

    // Taken branch, then branch with concurrent load-use
    step(); E_VALID = 1'b1; E_BR_TAKEN = 1'b1; E_BR_ADDR = 32'h40; settle();
    ctrl("br", 5'b00000, 5'b01100, 1'b1, 32'h40);
    step(); E_IS_LOAD = 1'b1; E_REG_D = 5'd7; D_USES_S1 = 1'b1; D_REG_S1 = 5'd7; settle();
    ctrl("br_lu", 5'b00000, 5'b01100, 1'b1, 32'h40);
    step(); idle(); settle();
    ctrl("br_done", 5'b00000, 5'b00000, 1'b0, 32'd0);
    chk("br_cnt", STALL_CNT, 32'd1);

    // Memory wait for 3 cycles; a branch during the wait is ignored
    for (int i = 0; i < 3; i++) begin
      step(); idle(); M_MEM_REQ = 1'b1;
      if (i == 1) begin E_VALID = 1'b1; E_BR_TAKEN = 1'b1; E_BR_ADDR = 32'h80; end
      settle();
      ctrl("mw", 5'b11110, 5'b00001, 1'b0, 32'd0);
    end
    step(); idle(); M_MEM_REQ = 1'b1; M_MEM_READY = 1'b1; settle();
    ctrl("mw_ready", 5'b00000, 5'b00000, 1'b0, 32'd0);
    step(); idle(); settle();
    chk("mw_cnt", STALL_CNT, 32'd4);
    chk("mw_err", {31'd0, MEM_ERR}, 32'd0);
    ctrl("mw_run", 5'b00000, 5'b00000, 1'b0, 32'd0);

    // Timeout: four wait cycles then ERR on the fifth
    for (int i = 0; i < 4; i++) begin
      step(); idle(); M_MEM_REQ = 1'b1; settle();
      ctrl("to_wait", 5'b11110, 5'b00001, 1'b0, 32'd0);
    end
    step(); settle();
    ctrl("to_err", 5'b00000, 5'b11111, 1'b1, 32'h100);
    chk("to_err_flag_pre", {31'd0, MEM_ERR}, 32'd0);
    step(); idle(); settle();
    chk("to_err_flag", {31'd0, MEM_ERR}, 32'd1);
    chk("to_cnt", STALL_CNT, 32'd8);
    ctrl("to_after", 5'b00000, 5'b00000, 1'b0, 32'd0);

    // Ready on the would-be timeout cycle suppresses the error
    for (int i = 0; i < 3; i++) begin
      step(); idle(); M_MEM_REQ = 1'b1; settle();
    end
    step(); M_MEM_READY = 1'b1; settle();
    ctrl("to_ready", 5'b00000, 5'b00000, 1'b0, 32'd0);
    step(); idle(); settle();
    ctrl("to_noerr", 5'b00000, 5'b00000, 1'b0, 32'd0);
    chk("to_ready_cnt", STALL_CNT, 32'd11);

    // Halt requested during memory wait is deferred
    for (int i = 0; i < 2; i++) begin
      step(); idle(); M_MEM_REQ = 1'b1; HALT_REQ = 1'b1; settle();
      chk("halt_defer", {31'd0, HALTED}, 32'd0);
      ctrl("halt_defer", 5'b11110, 5'b00001, 1'b0, 32'd0);
    end
    step(); M_MEM_READY = 1'b1; settle();
    chk("halt_ready", {31'd0, HALTED}, 32'd0);
    step(); idle(); HALT_REQ = 1'b1; settle();
    chk("halt_run", {31'd0, HALTED}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      step(); idle(); HALT_REQ = 1'b1;
      if (i == 4) begin M_MEM_REQ = 1'b1; E_VALID = 1'b1; E_BR_TAKEN = 1'b1; end
      settle();
      chk("halt_on", {31'd0, HALTED}, 32'd1);
      ctrl("halt_on", 5'b11111, 5'b00000, 1'b0, 32'd0);
    end
    chk("halt_cnt", STALL_CNT, 32'd22);
    step(); idle(); settle();
    chk("halt_release", {31'd0, HALTED}, 32'd0);
    step(); settle();
    chk("halt_gone", {31'd0, HALTED}, 32'd0);
    ctrl("halt_gone", 5'b00000, 5'b00000, 1'b0, 32'd0);

    // Reset in the middle of a memory wait with the error flag set
    for (int i = 0; i < 2; i++) begin
      step(); idle(); M_MEM_REQ = 1'b1; settle();
    end
    chk("rst2_pre_err", {31'd0, MEM_ERR}, 32'd1);
    step(); RST = 1'b1; HALT_REQ = 1'b1; settle();
    ctrl("rst2_quiet", 5'b00000, 5'b00000, 1'b0, 32'd0);
    chk("rst2_halted", {31'd0, HALTED}, 32'd0);
    step(); RST = 1'b0; idle(); settle();
    chk("rst2_err", {31'd0, MEM_ERR}, 32'd0);
    chk("rst2_cnt", STALL_CNT, 32'd0);
    ctrl("rst2_run", 5'b00000, 5'b00000, 1'b0, 32'd0);
    // Wait counter restarts: four wait cycles still precede ERR
    for (int i = 0; i < 4; i++) begin
      step(); idle(); M_MEM_REQ = 1'b1; settle();
      ctrl("rst2_wait", 5'b11110, 5'b00001, 1'b0, 32'd0);
    end
    step(); settle();
    ctrl("rst2_to", 5'b00000, 5'b11111, 1'b1, 32'h100);
    step(); idle(); settle();
    chk("rst2_cnt_end", STALL_CNT, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
